// File: rtl/mem_msg_pkg.sv
// rtl/mem_msg_pkg.sv - memory request/response message types shared by the arbiter and its bus
package mem_msg_pkg;

    localparam int P_ADDR_BITS   = 32;
    localparam int P_DATA_BITS   = 32;
    localparam int P_OPAQUE_BITS = 8;
    localparam int P_STRB_BITS   = P_DATA_BITS / 8;

    localparam logic MEM_OP_READ  = 1'b0;
    localparam logic MEM_OP_WRITE = 1'b1;

    typedef struct packed {
        logic                     op;
        logic [P_OPAQUE_BITS-1:0] opaque;
        logic [P_ADDR_BITS-1:0]   addr;
        logic [P_STRB_BITS-1:0]   strb;
        logic [P_DATA_BITS-1:0]   data;
    } mem_req_t;

    typedef struct packed {
        logic                     op;
        logic [P_OPAQUE_BITS-1:0] opaque;
        logic [P_DATA_BITS-1:0]   data;
    } mem_resp_t;

    function automatic logic is_pow2_ge2(int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/mem_req_arbiter_if.sv
// rtl/mem_req_arbiter_if.sv - handshake bundle between imem/dmem requesters, the arbiter and memory
interface mem_req_arbiter_if;
    import mem_msg_pkg::*;

    logic      req0_val;
    logic      req0_rdy;
    mem_req_t  req0_msg;
    logic      resp0_val;
    logic      resp0_rdy;
    mem_resp_t resp0_msg;

    logic      req1_val;
    logic      req1_rdy;
    mem_req_t  req1_msg;
    logic      resp1_val;
    logic      resp1_rdy;
    mem_resp_t resp1_msg;

    logic      mem_req_val;
    logic      mem_req_rdy;
    mem_req_t  mem_req_msg;
    logic      mem_resp_val;
    logic      mem_resp_rdy;
    mem_resp_t mem_resp_msg;

    // Arbiter side
    modport slave (
        input  req0_val, req0_msg, resp0_rdy,
        output req0_rdy, resp0_val, resp0_msg,
        input  req1_val, req1_msg, resp1_rdy,
        output req1_rdy, resp1_val, resp1_msg,
        output mem_req_val, mem_req_msg, mem_resp_rdy,
        input  mem_req_rdy, mem_resp_val, mem_resp_msg
    );

    // Environment side (requesters plus memory)
    modport master (
        output req0_val, req0_msg, resp0_rdy,
        input  req0_rdy, resp0_val, resp0_msg,
        output req1_val, req1_msg, resp1_rdy,
        input  req1_rdy, resp1_val, resp1_msg,
        input  mem_req_val, mem_req_msg, mem_resp_rdy,
        output mem_req_rdy, mem_resp_val, mem_resp_msg
    );

endinterface

// File: rtl/mem_req_arbiter_route_fifo.sv
// rtl/mem_req_arbiter_route_fifo.sv - in-order FIFO of 1-bit requester IDs for in-flight transactions
module route_fifo #(
    parameter  int p_depth  = 4,
    localparam int PTR_BITS = $clog2(p_depth)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic push_id,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    logic [p_depth-1:0]  ids_q,    ids_d;
    logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_BITS:0]   count_q,  count_d;

    // Callers never push when full or pop when empty; pointers wrap at the power-of-2 depth.
    always_comb begin
        ids_d    = ids_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            ids_d[wr_ptr_q] = push_id;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ids_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ids_q    <= ids_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign full  = (count_q == (PTR_BITS+1)'(p_depth));
    assign empty = (count_q == '0);
    assign head  = ids_q[rd_ptr_q];

endmodule

// File: rtl/mem_req_arbiter.sv
// rtl/mem_req_arbiter.sv - round-robin imem/dmem arbiter onto one memory port with in-order response routing
module mem_req_arbiter
    import mem_msg_pkg::*;
#(
    parameter int p_addr_bits    = 32,
    parameter int p_data_bits    = 32,
    parameter int p_opaque_bits  = 8,
    parameter int p_max_inflight = 4
) (
    input logic                clk,
    input logic                rst,
    mem_req_arbiter_if.slave   bus
);

    // Message layouts are fixed by the package; reject mismatched or illegal sizing at elaboration.
    if (p_addr_bits != P_ADDR_BITS || p_data_bits != P_DATA_BITS ||
        p_opaque_bits != P_OPAQUE_BITS) begin : g_bad_width
        $error("mem_req_arbiter: widths must match mem_msg_pkg");
    end
    if (!is_pow2_ge2(p_max_inflight)) begin : g_bad_depth
        $error("mem_req_arbiter: p_max_inflight must be a power of 2, at least 2");
    end

    logic prio_q, prio_d;
    logic winner;
    logic can_issue;
    logic push, pop;
    logic fifo_full, fifo_empty, head_id;
    logic resp_dest_val;

    always_comb begin
        winner = bus.req1_val;
        if (bus.req0_val && bus.req1_val) begin
            winner = prio_q;
        end
        push   = bus.mem_req_val && bus.mem_req_rdy;
        prio_d = prio_q;
        if (push) begin
            prio_d = !winner;
        end
    end

    // Full FIFO blocks grants regardless of a same-cycle pop, keeping resp->req free of comb paths.
    assign can_issue        = !rst && !fifo_full && bus.mem_req_rdy;
    assign bus.mem_req_val  = !rst && !fifo_full && (bus.req0_val || bus.req1_val);
    assign bus.mem_req_msg  = winner ? bus.req1_msg : bus.req0_msg;
    assign bus.req0_rdy     = can_issue && !winner;
    assign bus.req1_rdy     = can_issue &&  winner;

    assign resp_dest_val    = !rst && bus.mem_resp_val && !fifo_empty;
    assign bus.resp0_val    = resp_dest_val && !head_id;
    assign bus.resp1_val    = resp_dest_val &&  head_id;
    assign bus.resp0_msg    = bus.mem_resp_msg;
    assign bus.resp1_msg    = bus.mem_resp_msg;
    assign bus.mem_resp_rdy = !rst && !fifo_empty && (head_id ? bus.resp1_rdy : bus.resp0_rdy);
    assign pop              = bus.mem_resp_val && bus.mem_resp_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

    route_fifo #(
        .p_depth (p_max_inflight)
    ) u_route_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .push_id (winner),
        .pop     (pop),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head_id)
    );

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && bus.mem_resp_val) begin
            assert (!fifo_empty)
                else $error("mem_req_arbiter: memory response with no transaction in flight");
        end
    end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb/tb_mem_req_arbiter.sv - directed self-checking bench for mem_req_arbiter
module tb_mem_req_arbiter;
    import mem_msg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    mem_req_arbiter_if bus ();

    mem_req_arbiter #(
        .p_addr_bits    (32),
        .p_data_bits    (32),
        .p_opaque_bits  (8),
        .p_max_inflight (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkv(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_t mk_req(input logic op, input logic [7:0] opq,
                                        input logic [31:0] addr, input logic [3:0] strb,
                                        input logic [31:0] data);
        mem_req_t r;
        r = {op, opq, addr, strb, data};
        return r;
    endfunction

    function automatic mem_resp_t mk_resp(input logic op, input logic [7:0] opq, input logic [31:0] data);
        mem_resp_t r;
        r = {op, opq, data};
        return r;
    endfunction

    task automatic idle();
        bus.req0_val     = 1'b0;
        bus.req1_val     = 1'b0;
        bus.req0_msg     = '0;
        bus.req1_msg     = '0;
        bus.mem_req_rdy  = 1'b1;
        bus.mem_resp_val = 1'b0;
        bus.mem_resp_msg = '0;
        bus.resp0_rdy    = 1'b1;
        bus.resp1_rdy    = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_quiet(input string tag);
        chk1({tag, "_mem_req_val"},  bus.mem_req_val,  1'b0);
        chk1({tag, "_req0_rdy"},     bus.req0_rdy,     1'b0);
        chk1({tag, "_req1_rdy"},     bus.req1_rdy,     1'b0);
        chk1({tag, "_resp0_val"},    bus.resp0_val,    1'b0);
        chk1({tag, "_resp1_val"},    bus.resp1_val,    1'b0);
        chk1({tag, "_mem_resp_rdy"}, bus.mem_resp_rdy, 1'b0);
    endtask

    mem_req_t  r0, r1;
    mem_resp_t rs;
    logic      exp_w;
    logic      exp_d;

    initial begin
        // Reset with everything requesting
        idle();
        rst = 1'b1;
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1;
        bus.mem_resp_val = 1'b1;
        tick();
        #1;
        check_all_quiet("rst0");
        tick();
        idle();
        rst = 1'b0;
        #1;
        chk1("rst0_empty_rdy", bus.mem_resp_rdy, 1'b0);

        // Single imem read
        r0 = mk_req(MEM_OP_READ, 8'h01, 32'h200, 4'h0, 32'h0);
        bus.req0_msg = r0;
        bus.req0_val = 1'b1;
        #1;
        chk1("t1_mem_req_val", bus.mem_req_val, 1'b1);
        chkv("t1_mem_req_msg", 128'(bus.mem_req_msg), 128'(r0));
        chk1("t1_req0_rdy", bus.req0_rdy, 1'b1);
        chk1("t1_req1_rdy", bus.req1_rdy, 1'b0);
        tick();
        bus.req0_val = 1'b0;
        rs = mk_resp(MEM_OP_READ, 8'h01, 32'hDEADBEEF);
        bus.mem_resp_msg = rs;
        bus.mem_resp_val = 1'b1;
        #1;
        chk1("t1_resp0_val", bus.resp0_val, 1'b1);
        chk1("t1_resp1_val", bus.resp1_val, 1'b0);
        chkv("t1_resp0_msg", 128'(bus.resp0_msg), 128'(rs));
        chk1("t1_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
        tick();
        idle();

        // Both valid for 6 cycles after reset: grants 0,1,0,1,0,1 with 1-cycle responses
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 7; k++) begin
            bus.req0_val = (k < 6);
            bus.req1_val = (k < 6);
            bus.req0_msg = mk_req(MEM_OP_READ, 8'h10 + 8'(k), 32'h1000 + 32'(4*k), 4'h0, 32'h0);
            bus.req1_msg = mk_req(MEM_OP_READ, 8'h20 + 8'(k), 32'h2000 + 32'(4*k), 4'h0, 32'h0);
            bus.mem_resp_val = (k > 0);
            bus.mem_resp_msg = mk_resp(MEM_OP_READ, 8'h40 + 8'(k), 32'hA000 + 32'(k));
            #1;
            if (k < 6) begin
                exp_w = (k % 2 == 1);
                chk1($sformatf("t2_req0_rdy_%0d", k), bus.req0_rdy, !exp_w);
                chk1($sformatf("t2_req1_rdy_%0d", k), bus.req1_rdy, exp_w);
                chkv($sformatf("t2_opaque_%0d", k), 128'(bus.mem_req_msg.opaque),
                     128'(exp_w ? 8'h20 + 8'(k) : 8'h10 + 8'(k)));
            end
            if (k > 0) begin
                exp_d = ((k - 1) % 2 == 1);
                chk1($sformatf("t2_resp0_val_%0d", k), bus.resp0_val, !exp_d);
                chk1($sformatf("t2_resp1_val_%0d", k), bus.resp1_val, exp_d);
                chk1($sformatf("t2_mem_resp_rdy_%0d", k), bus.mem_resp_rdy, 1'b1);
            end
            tick();
        end
        idle();

        // Responses stalled: 4 grants fill the FIFO, 5th cycle blocked even with a pop
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk1($sformatf("t3_mem_req_val_%0d", k), bus.mem_req_val, 1'b1);
            chk1($sformatf("t3_req0_rdy_%0d", k), bus.req0_rdy, (k % 2 == 0));
            tick();
        end
        bus.mem_resp_val = 1'b1;
        bus.mem_resp_msg = mk_resp(MEM_OP_READ, 8'h50, 32'h55);
        #1;
        chk1("t3_full_mem_req_val", bus.mem_req_val, 1'b0);
        chk1("t3_full_req0_rdy", bus.req0_rdy, 1'b0);
        chk1("t3_full_req1_rdy", bus.req1_rdy, 1'b0);
        chk1("t3_full_resp0_val", bus.resp0_val, 1'b1);
        chk1("t3_full_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
        tick();
        bus.mem_resp_val = 1'b0;
        #1;
        chk1("t3_regrant_val", bus.mem_req_val, 1'b1);
        chk1("t3_regrant_req0_rdy", bus.req0_rdy, 1'b1);
        tick();
        bus.req0_val = 1'b0;
        bus.req1_val = 1'b0;

        // FIFO now holds dests 1,0,1,0; hold port 1 not ready
        bus.mem_resp_val = 1'b1;
        bus.resp1_rdy = 1'b0;
        #1;
        chk1("t4_hold_resp1_val", bus.resp1_val, 1'b1);
        chk1("t4_hold_resp0_val", bus.resp0_val, 1'b0);
        chk1("t4_hold_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        tick();
        tick();
        #1;
        chk1("t4_still_resp1_val", bus.resp1_val, 1'b1);
        chk1("t4_still_resp0_val", bus.resp0_val, 1'b0);
        chk1("t4_still_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        bus.resp1_rdy = 1'b1;
        #1;
        chk1("t4_release_mem_resp_rdy", bus.mem_resp_rdy, 1'b1);
        tick();
        #1;
        chk1("t4_d1_resp0_val", bus.resp0_val, 1'b1);
        chk1("t4_d1_resp1_val", bus.resp1_val, 1'b0);
        tick();
        #1;
        chk1("t4_d2_resp1_val", bus.resp1_val, 1'b1);
        tick();
        #1;
        chk1("t4_d3_resp0_val", bus.resp0_val, 1'b1);
        tick();
        bus.mem_resp_val = 1'b0;
        #1;
        chk1("t4_empty_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);

        // dmem store then imem read, responses in request order
        r1 = mk_req(MEM_OP_WRITE, 8'h33, 32'h300, 4'hF, 32'h12345678);
        bus.req1_msg = r1;
        bus.req1_val = 1'b1;
        #1;
        chkv("t5_sw_msg", 128'(bus.mem_req_msg), 128'(r1));
        chk1("t5_sw_req1_rdy", bus.req1_rdy, 1'b1);
        tick();
        bus.req1_val = 1'b0;
        r0 = mk_req(MEM_OP_READ, 8'h34, 32'h400, 4'h0, 32'h0);
        bus.req0_msg = r0;
        bus.req0_val = 1'b1;
        #1;
        chk1("t5_rd_req0_rdy", bus.req0_rdy, 1'b1);
        chkv("t5_rd_msg", 128'(bus.mem_req_msg), 128'(r0));
        tick();
        bus.req0_val = 1'b0;
        rs = mk_resp(MEM_OP_WRITE, 8'h33, 32'h0);
        bus.mem_resp_msg = rs;
        bus.mem_resp_val = 1'b1;
        #1;
        chk1("t5_wr_resp1_val", bus.resp1_val, 1'b1);
        chk1("t5_wr_resp0_val", bus.resp0_val, 1'b0);
        chkv("t5_wr_resp1_msg", 128'(bus.resp1_msg), 128'(rs));
        tick();
        rs = mk_resp(MEM_OP_READ, 8'h34, 32'hCAFEF00D);
        bus.mem_resp_msg = rs;
        #1;
        chk1("t5_rd_resp0_val", bus.resp0_val, 1'b1);
        chk1("t5_rd_resp1_val", bus.resp1_val, 1'b0);
        chkv("t5_rd_resp0_msg", 128'(bus.resp0_msg), 128'(rs));
        tick();
        idle();

        // Reset with 3 in flight
        bus.req0_msg = mk_req(MEM_OP_READ, 8'h60, 32'h600, 4'h0, 32'h0);
        bus.req0_val = 1'b1;
        tick();
        tick();
        tick();
        rst = 1'b1;
        bus.req1_val = 1'b1;
        bus.mem_resp_val = 1'b1;
        #1;
        check_all_quiet("t6_rst");
        tick();
        rst = 1'b0;
        idle();
        #1;
        chk1("t6_empty_mem_resp_rdy", bus.mem_resp_rdy, 1'b0);
        r0 = mk_req(MEM_OP_READ, 8'h70, 32'h700, 4'h0, 32'h0);
        r1 = mk_req(MEM_OP_READ, 8'h71, 32'h704, 4'h0, 32'h0);
        bus.req0_msg = r0;
        bus.req1_msg = r1;
        bus.req0_val = 1'b1;
        bus.req1_val = 1'b1;
        bus.mem_req_rdy = 1'b0;
        #1;
        chk1("t6_prio_val", bus.mem_req_val, 1'b1);
        chkv("t6_prio_msg", 128'(bus.mem_req_msg), 128'(r0));
        chk1("t6_prio_req0_rdy", bus.req0_rdy, 1'b0);
        tick();
        bus.req0_val = 1'b0;
        r1 = mk_req(MEM_OP_READ, 8'h77, 32'h500, 4'h0, 32'h0);
        bus.req1_msg = r1;
        bus.mem_req_rdy = 1'b1;
        #1;
        chk1("t6_fresh_req1_rdy", bus.req1_rdy, 1'b1);
        chkv("t6_fresh_msg", 128'(bus.mem_req_msg), 128'(r1));
        tick();
        bus.req1_val = 1'b0;
        rs = mk_resp(MEM_OP_READ, 8'h77, 32'h600D);
        bus.mem_resp_msg = rs;
        bus.mem_resp_val = 1'b1;
        #1;
        chk1("t6_resp1_val", bus.resp1_val, 1'b1);
        chk1("t6_resp0_val", bus.resp0_val, 1'b0);
        chkv("t6_resp1_msg", 128'(bus.resp1_msg), 128'(rs));
        tick();
        idle();
        #1;
        chk1("t6_final_empty", bus.mem_resp_rdy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
